fpu_vector_sequencer: RTL and testbench

// Parametrised sequencer for running test vectors through a bank of lockstep FPU channels on the DE1-SoC.
// - Steps an address through the operand/rmode/opcode ROMs, waits out the ROM read latency, issues one start pulse to every channel, then collects each channel's ready edge.
// - Writes all channel results to the result RAMs and compares every channel against channel 0.
// - Keeps mismatch and timeout statistics. Supports single-pass and loop modes.

---
 rtl/fpu_vector_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fpu_vector_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_vector_sequencer.sv
// fpu_vector_sequencer: steps test vectors through a bank of lockstep FPU channels,
// captures each channel's result on its ready edge, writes results out and compares against channel 0.
`default_nettype none

module fpu_vector_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int ADDR_W  = 12,
    parameter int RES_W   = 70,
    parameter int ROM_LAT = 2,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [ADDR_W-1:0]       num_vec,
    input  logic [NUM_CH-1:0]       ch_ready,
    input  logic [NUM_CH*RES_W-1:0] ch_result,
    output logic [ADDR_W-1:0]       vec_addr,
    output logic                    fpu_start,
    output logic                    ram_wren,
    output logic [NUM_CH*RES_W-1:0] ram_data,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [ADDR_W-1:0]       first_err_addr,
    output logic                    err_valid,
    output logic [NUM_CH-1:0]       ch_err_mask,
    output logic                    timeout_flag
);

    localparam int TW = $clog2(TIMEOUT + ROM_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]              state;
    logic [TW-1:0]           timer;
    logic [NUM_CH-1:0]       ready_q;
    logic [NUM_CH-1:0]       seen;
    logic [NUM_CH-1:0]       ready_edge;
    logic [NUM_CH-1:0]       seen_next;
    logic [NUM_CH-1:0]       diff;
    logic [NUM_CH*RES_W-1:0] cap;
    logic [ADDR_W-1:0]       last_addr;

    // Ready edges only count while waiting; edges in other states are dropped.
    assign ready_edge = ch_ready & ~ready_q & {NUM_CH{state == S_WAIT}};
    assign seen_next  = seen | ready_edge;

    always_comb begin
        diff = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            diff[i] = (cap[i*RES_W +: RES_W] != cap[0 +: RES_W]);
        end
    end

    assign fpu_start = (state == S_ISSUE);
    assign ram_wren  = (state == S_WRITE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign ram_data  = cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= '0;
        end else begin
            ready_q <= ch_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            seen           <= '0;
            cap            <= '0;
            vec_addr       <= '0;
            last_addr      <= '0;
            mismatch_cnt   <= '0;
            first_err_addr <= '0;
            err_valid      <= 1'b0;
            ch_err_mask    <= '0;
            timeout_flag   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ready_edge[i]) begin
                    cap[i*RES_W +: RES_W] <= ch_result[i*RES_W +: RES_W];
                end
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mismatch_cnt   <= '0;
                        first_err_addr <= '0;
                        err_valid      <= 1'b0;
                        ch_err_mask    <= '0;
                        timeout_flag   <= 1'b0;
                        vec_addr       <= '0;
                        timer          <= '0;
                        last_addr      <= num_vec - 1'b1;
                        state          <= (num_vec == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (timer == TW'(ROM_LAT - 1)) begin
                        timer <= '0;
                        state <= S_ISSUE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ISSUE: begin
                    seen  <= '0;
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    seen <= seen_next;
                    if (&seen_next) begin
                        state <= S_WRITE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_flag <= 1'b1;
                        ch_err_mask  <= ch_err_mask | ~seen_next;
                        state        <= S_WRITE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (|diff) begin
                        if (mismatch_cnt != {CNT_W{1'b1}}) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                        end
                        ch_err_mask <= ch_err_mask | diff;
                        if (!err_valid) begin
                            first_err_addr <= vec_addr;
                            err_valid      <= 1'b1;
                        end
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    timer <= '0;
                    if (vec_addr != last_addr) begin
                        vec_addr <= vec_addr + 1'b1;
                        state    <= S_FETCH;
                    end else if (loop_en && !stop) begin
                        vec_addr <= '0;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_vector_sequencer.sv
// Testbench for fpu_vector_sequencer: behavioural FPU bank plus table-driven runs and corner sequences.
`default_nettype none

module tb_fpu_vector_sequencer;

    localparam int NUM_CH  = 8;
    localparam int ADDR_W  = 12;
    localparam int RES_W   = 70;
    localparam int ROM_LAT = 2;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    stop = 1'b0;
    logic                    loop_en = 1'b0;
    logic [ADDR_W-1:0]       num_vec = '0;
    logic [NUM_CH-1:0]       ch_ready = '0;
    logic [NUM_CH*RES_W-1:0] ch_result = '0;
    logic [ADDR_W-1:0]       vec_addr;
    logic                    fpu_start;
    logic                    ram_wren;
    logic [NUM_CH*RES_W-1:0] ram_data;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        mismatch_cnt;
    logic [ADDR_W-1:0]       first_err_addr;
    logic                    err_valid;
    logic [NUM_CH-1:0]       ch_err_mask;
    logic                    timeout_flag;

    fpu_vector_sequencer #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RES_W(RES_W),
        .ROM_LAT(ROM_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .num_vec(num_vec), .ch_ready(ch_ready), .ch_result(ch_result),
        .vec_addr(vec_addr), .fpu_start(fpu_start), .ram_wren(ram_wren),
        .ram_data(ram_data), .busy(busy), .done(done),
        .mismatch_cnt(mismatch_cnt), .first_err_addr(first_err_addr),
        .err_valid(err_valid), .ch_err_mask(ch_err_mask), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // FPU bank configuration
    int                err_ch   = 0;
    int                err_addr = 4095;
    bit                err_all  = 1'b0;
    logic [NUM_CH-1:0] dead     = '0;

    function automatic logic [RES_W-1:0] exp_res(input int ch, input logic [ADDR_W-1:0] a);
        logic [RES_W-1:0] d;
        d = {64'(a) * 64'd1000, 6'd0};
        if (ch == err_ch && (err_all || int'(a) == err_addr)) d = d ^ 70'd64;
        return d;
    endfunction

    // Every channel drops ready on start and raises it 5 cycles later with its result.
    int                lat = 0;
    logic [ADDR_W-1:0] laddr = '0;
    always @(posedge clk) begin
        if (fpu_start) begin
            ch_ready <= '0;
            lat      <= 5;
            laddr    <= vec_addr;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                ch_ready <= ~dead;
                for (int c = 0; c < NUM_CH; c++) ch_result[c*RES_W +: RES_W] <= exp_res(c, laddr);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int nv, input bit lp, input int stop_after, input int bstart,
                           output int writes, output int wait_c, output int cyc);
        int n;
        writes = 0; wait_c = 0; n = 0; cyc = 0;
        @(negedge clk);
        num_vec = ADDR_W'(nv); loop_en = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_vec = '1;
        while (!done && cyc < 4000) begin
            start = 1'b0;
            if (fpu_start) begin
                n = 0;
                if (stop_after >= 0 && writes >= stop_after && vec_addr == '0) stop = 1'b1;
                if (bstart >= 0 && writes == bstart) start = 1'b1;
            end else begin
                n++;
            end
            if (ram_wren) begin
                chk("wr_addr", vec_addr, writes % nv);
                chk("wr_ch0", ram_data[0 +: RES_W], exp_res(0, vec_addr));
                chk("wr_ch1", ram_data[RES_W +: RES_W], exp_res(1, vec_addr));
                wait_c = n - 1;
                writes++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("run_done", done, 1'b1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    typedef struct {
        int                nv;
        int                ech;
        int                eaddr;
        bit                eall;
        logic [NUM_CH-1:0] dmask;
        int                x_writes;
        int                x_wait;
        int                x_mc;
        bit                x_ev;
        int                x_fea;
        logic [NUM_CH-1:0] x_mask;
        bit                x_to;
        int                x_addr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int w, wc, cy, k;
        // nv ech eaddr eall dead | writes wait mc ev fea mask to addr
        tbl[0] = '{3,  0, 4095, 1'b0, 8'h00, 3,  6,  0,  1'b0, 0, 8'h00, 1'b0, 2};
        tbl[1] = '{10, 3, 5,    1'b0, 8'h00, 10, 6,  1,  1'b1, 5, 8'h08, 1'b0, 9};
        // ch7 never answers: its stale capture (vector 9 of the previous run) differs from ch0 at vector 0
        tbl[2] = '{1,  0, 4095, 1'b0, 8'h80, 1,  64, 1,  1'b1, 0, 8'h80, 1'b1, 0};
        tbl[3] = '{20, 1, 4095, 1'b1, 8'h00, 20, 6,  15, 1'b1, 0, 8'h02, 1'b0, 19};
        tbl[4] = '{0,  0, 4095, 1'b0, 8'h00, 0,  0,  0,  1'b0, 0, 8'h00, 1'b0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", vec_addr, 0);
        chk("rst_start", fpu_start, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_data", |ram_data, 0);
        chk("rst_stats", {mismatch_cnt, first_err_addr, err_valid, ch_err_mask, timeout_flag}, 0);

        for (int i = 0; i < 5; i++) begin
            err_ch = tbl[i].ech; err_addr = tbl[i].eaddr; err_all = tbl[i].eall; dead = tbl[i].dmask;
            run_vec(tbl[i].nv, 1'b0, -1, -1, w, wc, cy);
            chk("writes", w, tbl[i].x_writes);
            chk("wait_len", wc, tbl[i].x_wait);
            chk("mismatch_cnt", mismatch_cnt, tbl[i].x_mc);
            chk("err_valid", err_valid, tbl[i].x_ev);
            chk("first_err_addr", first_err_addr, tbl[i].x_fea);
            chk("ch_err_mask", ch_err_mask, tbl[i].x_mask);
            chk("timeout_flag", timeout_flag, tbl[i].x_to);
            chk("busy_idle", busy, 0);
            if (tbl[i].nv != 0) chk("final_addr", vec_addr, tbl[i].x_addr);
            else chk("done_latency", cy, 0);
        end

        // loop mode: stop raised during the third pass's vector 0
        err_ch = 0; err_addr = 4095; err_all = 1'b0; dead = '0;
        run_vec(2, 1'b1, 4, -1, w, wc, cy);
        chk("loop_writes", w, 6);
        chk("loop_addr", vec_addr, 1);
        loop_en = 1'b0;

        // start pulsed during vector 1 must not restart the run
        run_vec(3, 1'b0, -1, 1, w, wc, cy);
        chk("busy_start_writes", w, 3);
        chk("busy_start_addr", vec_addr, 2);

        // reset while waiting on vector 1 of a mismatching run
        err_ch = 1; err_all = 1'b1;
        @(negedge clk);
        num_vec = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!ram_wren && k < 200) begin @(negedge clk); k++; end
        while (!fpu_start && k < 200) begin @(negedge clk); k++; end
        chk("pre_rst_bound", k < 200, 1);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_mc", mismatch_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_busy", busy, 0);
        chk("wait_rst_addr", vec_addr, 0);
        chk("wait_rst_data", |ram_data, 0);
        chk("wait_rst_stats", {done, mismatch_cnt, err_valid, ch_err_mask, timeout_flag}, 0);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_wren || busy) k++;
        end
        chk("post_rst_quiet", k, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
